// File: rtl/kp_key_injector.sv
// rtl/kp_key_injector.sv - operator keypad emulator answering column strobes with a row pattern
module kp_key_injector #(
  parameter int HOLD_SCANS    = 4,
  parameter int RELEASE_SCANS = 2
) (
  input  logic       i_sys_clock,
  input  logic       i_sys_reset,
  input  logic       i_kp_req_valid,
  output logic       o_kp_req_ready,
  input  logic [3:0] i_kp_req_keycode,
  input  logic       i_kp_abort,
  input  logic [3:0] i_kp_keypad_column,
  output logic [3:0] o_kp_keypad_row,
  output logic       o_kp_busy,
  output logic       o_kp_done,
  output logic       o_kp_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam logic [3:0] LP_HOLD    = HOLD_SCANS[3:0];
  localparam logic [3:0] LP_RELEASE = RELEASE_SCANS[3:0];
  localparam logic [3:0] LP_KEY_MAX = 4'hC;
  localparam logic [3:0] LP_ALL_HI  = 4'b1111;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic [3:0] r_key;
  logic [3:0] w_key_nxt;
  logic [3:0] w_row_nxt;
  logic       w_done_nxt;
  logic       w_err_nxt;

  logic       w_idle_slot;
  logic [3:0] w_cnt_inc;
  logic [3:0] w_col_ahead;
  logic [3:0] w_target_col;
  logic [3:0] w_row_pat;

  // Scanner column sequence; anything unexpected restarts at the first column.
  function automatic logic [3:0] f_next_col(input logic [3:0] col);
    case (col)
      4'b1110: f_next_col = 4'b1101;
      4'b1101: f_next_col = 4'b1011;
      4'b1011: f_next_col = 4'b0111;
      4'b0111: f_next_col = 4'b1111;
      default: f_next_col = 4'b1110;
    endcase
  endfunction

  assign w_idle_slot  = (i_kp_keypad_column == LP_ALL_HI);
  assign w_cnt_inc    = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
  // The scanner registers our row and pairs it with the column after next.
  assign w_col_ahead  = f_next_col(f_next_col(i_kp_keypad_column));
  assign w_target_col = ~(4'b0001 << r_key[3:2]);
  assign w_row_pat    = ~(4'b0001 << r_key[1:0]);

  // Next-state, counter, latched keycode and registered-output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_key_nxt   = r_key;
    w_row_nxt   = LP_ALL_HI;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_kp_req_valid) begin
          if (i_kp_req_keycode <= LP_KEY_MAX) begin
            w_key_nxt   = i_kp_req_keycode;
            w_cnt_nxt   = 4'd0;
            w_state_nxt = ST_PRESS;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_PRESS: begin
        if (i_kp_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_idle_slot) begin
          if (w_cnt_inc == LP_HOLD) begin
            w_cnt_nxt   = 4'd0;
            w_state_nxt = ST_RELEASE;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        if (w_state_nxt == ST_PRESS && w_col_ahead == w_target_col) begin
          w_row_nxt = w_row_pat;
        end
      end
      ST_RELEASE: begin
        if (i_kp_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_idle_slot) begin
          if (w_cnt_inc == LP_RELEASE) begin
            w_cnt_nxt   = 4'd0;
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset releases the key immediately.
  always_ff @(posedge i_sys_clock or posedge i_sys_reset) begin
    if (i_sys_reset) begin
      r_state         <= ST_IDLE;
      r_cnt           <= 4'd0;
      r_key           <= LP_ALL_HI;
      o_kp_keypad_row <= LP_ALL_HI;
      o_kp_req_ready  <= 1'b1;
      o_kp_busy       <= 1'b0;
      o_kp_done       <= 1'b0;
      o_kp_err        <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_cnt           <= w_cnt_nxt;
      r_key           <= w_key_nxt;
      o_kp_keypad_row <= w_row_nxt;
      o_kp_req_ready  <= (w_state_nxt == ST_IDLE);
      o_kp_busy       <= (w_state_nxt != ST_IDLE);
      o_kp_done       <= w_done_nxt;
      o_kp_err        <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_kp_key_injector.sv
// tb/tb_kp_key_injector.sv - directed self-checking bench for kp_key_injector
module tb_kp_key_injector;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_keycode;
  logic       abort;
  logic [3:0] col;
  logic [3:0] row;
  logic       busy;
  logic       done;
  logic       err;

  int n_checks;
  int n_errors;

  // scanner model state
  logic [3:0] row_q;
  logic       held;
  logic       seen_rot;
  logic       neg_flag;
  logic [3:0] emit_q[$];
  logic [3:0] exp_col;
  logic [3:0] allowed_row;
  int         bad_pair;
  int         bad_row;

  kp_key_injector #(.HOLD_SCANS(4), .RELEASE_SCANS(2)) u_dut (
    .i_sys_clock        (clk),
    .i_sys_reset        (rst),
    .i_kp_req_valid     (req_valid),
    .o_kp_req_ready     (req_ready),
    .i_kp_req_keycode   (req_keycode),
    .i_kp_abort         (abort),
    .i_kp_keypad_column (col),
    .o_kp_keypad_row    (row),
    .o_kp_busy          (busy),
    .o_kp_done          (done),
    .o_kp_err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] f_next(input logic [3:0] c);
    case (c)
      4'b1110: f_next = 4'b1101;
      4'b1101: f_next = 4'b1011;
      4'b1011: f_next = 4'b0111;
      4'b0111: f_next = 4'b1111;
      default: f_next = 4'b1110;
    endcase
  endfunction

  function automatic logic [1:0] f_idx(input logic [3:0] v);
    f_idx = 2'd0;
    for (int i = 0; i < 4; i++) if (v[i] == 1'b0) f_idx = 2'(i);
  endfunction

  // Free-running scanner: captures the row each cycle and pairs it with the following column.
  always @(posedge clk) begin
    logic [3:0] nc;
    logic [3:0] code;
    #1;
    nc = f_next(col);
    if (nc == 4'b1111) begin
      if (!seen_rot) held = 1'b0;
      seen_rot = 1'b0;
    end else if (row_q != 4'b1111) begin
      seen_rot = 1'b1;
      if (exp_col != 4'h0 && (nc != exp_col || row_q != allowed_row)) bad_pair++;
      code = {f_idx(nc), f_idx(row_q)};
      if (!held) begin
        held = 1'b1;
        if (code == 4'hC) neg_flag = 1'b1;
        else emit_q.push_back(code);
      end
    end
    if (allowed_row != 4'h0 && row != 4'b1111 && row != allowed_row) bad_row++;
    row_q = row;
    col   = nc;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  task automatic wait_idle_slots(input int n_slots, output int got);
    got = 0;
    for (int i = 0; i < 60 && got < n_slots; i++) begin
      @(negedge clk);
      if (col == 4'b1111) got++;
    end
  endtask

  // accept a request in the current cycle; returns at the first busy cycle
  task automatic send(input logic [3:0] k);
    req_valid   = 1'b1;
    req_keycode = k;
    step();
    req_valid   = 1'b0;
  endtask

  initial begin
    int lat;
    int n;
    int got;
    n_checks = 0; n_errors = 0;
    row_q = 4'hF; held = 1'b0; seen_rot = 1'b0; neg_flag = 1'b0;
    exp_col = 4'h0; allowed_row = 4'h0; bad_pair = 0; bad_row = 0;
    col = 4'b1111; rst = 1'b1; req_valid = 1'b0; req_keycode = 4'h0; abort = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_row", row, 4'b1111);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    repeat (2) step();

    // keycode 0x5 with the handshake aligned to column 1101
    for (int i = 0; i < 10 && col != 4'b1101; i++) step();
    chk("k5_phase", col, 4'b1101);
    exp_col = 4'b1101; allowed_row = 4'b1101; emit_q.delete(); bad_pair = 0; bad_row = 0;
    @(negedge clk);
    chk("k5_ready_pre", req_ready, 1);
    #2;
    send(4'h5);
    @(negedge clk);
    chk("k5_busy", busy, 1);
    chk("k5_ready_low", req_ready, 0);
    wait_done(60, lat);
    chk("k5_done_lat", 32'((lat + 1 >= 28) && (lat + 1 <= 32)), 1);
    chk("k5_done_exact", lat + 1, 29);
    chk("k5_idle_busy", busy, 0);
    @(negedge clk);
    chk("k5_done_width", done, 0);
    chk("k5_emit_n", emit_q.size(), 1);
    if (emit_q.size() > 0) chk("k5_emit_code", emit_q[0], 4'h5);
    chk("k5_neg", neg_flag, 0);
    chk("k5_bad_row", bad_row, 0);
    chk("k5_bad_pair", bad_pair, 0);

    // sign key 0xC
    step();
    exp_col = 4'b0111; allowed_row = 4'b1110; emit_q.delete(); bad_pair = 0; bad_row = 0;
    send(4'hC);
    wait_done(60, lat);
    chk("kc_done_seen", 32'(lat > 0), 1);
    step(); step();
    chk("kc_neg", neg_flag, 1);
    chk("kc_emit_n", emit_q.size(), 0);
    chk("kc_bad_pair", bad_pair, 0);
    chk("kc_bad_row", bad_row, 0);

    // invalid keycodes
    exp_col = 4'h0; allowed_row = 4'h0;
    for (int k = 0; k < 2; k++) begin
      logic [3:0] kc;
      kc = (k == 0) ? 4'hD : 4'hF;
      req_valid = 1'b1; req_keycode = kc;
      step();
      req_valid = 1'b0;
      @(negedge clk);
      chk("inv_err", err, 1);
      chk("inv_ready", req_ready, 1);
      chk("inv_busy", busy, 0);
      chk("inv_row", row, 4'b1111);
      @(negedge clk);
      chk("inv_err_width", err, 0);
      #2;
    end

    // valid held high: 0x0 then 0xB
    step();
    emit_q.delete();
    send(4'h0);
    req_valid = 1'b1; req_keycode = 4'hB;
    @(negedge clk);
    chk("b2b_busy", busy, 1);
    wait_done(60, lat);
    chk("b2b_done1", 32'(lat > 0), 1);
    chk("b2b_ready_at_done", req_ready, 1);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_accept2", busy, 1);
    wait_done(60, lat);
    chk("b2b_done2", 32'(lat > 0), 1);
    step(); step();
    chk("b2b_emit_n", emit_q.size(), 2);
    if (emit_q.size() == 2) begin
      chk("b2b_emit0", emit_q[0], 4'h0);
      chk("b2b_emit1", emit_q[1], 4'hB);
    end

    // abort two scans into PRESS
    send(4'h5);
    wait_idle_slots(2, got);
    chk("abp_slots", got, 2);
    step();
    abort = 1'b1;
    @(negedge clk);
    chk("abp_busy_pre", busy, 1);
    step();
    abort = 1'b0;
    @(negedge clk);
    chk("abp_row", row, 4'b1111);
    chk("abp_busy", busy, 0);
    chk("abp_ready", req_ready, 1);
    count_done(40, n);
    chk("abp_no_done", n, 0);

    // abort in RELEASE
    #2;
    send(4'h6);
    wait_idle_slots(5, got);
    chk("abr_slots", got, 5);
    step();
    abort = 1'b1;
    @(negedge clk);
    chk("abr_busy_pre", busy, 1);
    chk("abr_row_rel", row, 4'b1111);
    step();
    abort = 1'b0;
    @(negedge clk);
    chk("abr_row", row, 4'b1111);
    chk("abr_busy", busy, 0);
    chk("abr_ready", req_ready, 1);
    count_done(40, n);
    chk("abr_no_done", n, 0);

    // asynchronous reset mid-press
    #2;
    send(4'h5);
    for (int i = 0; i < 20 && row == 4'b1111; i++) @(negedge clk);
    chk("rmp_row_driven", row, 4'b1101);
    #2;
    rst = 1'b1;
    #1;
    chk("rmp_row", row, 4'b1111);
    chk("rmp_busy", busy, 0);
    chk("rmp_ready", req_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("rmp_ready_after", req_ready, 1);
    chk("rmp_busy_after", busy, 0);
    count_done(40, n);
    chk("rmp_no_done", n, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
